// File: rtl/gate_guard_3l.sv
// Gate-command guard for one 3-level phase leg: dwell filtering, shoot-through and desat protection.
// Optional macro GATE_GUARD_DESAT_EN adds per-switch desaturation filters and the desat fault cause.
module gate_guard_3l #(
  parameter int unsigned FLT_FILT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       en,
  input  logic [5:0] s_in,
  input  logic [7:0] t_min,
  input  logic [5:0] desat_n,
  input  logic       flt_clr,
  output logic [5:0] s_out,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [5:0] s_out_q, s_out_d;
  logic [7:0] dwell_q [6];
  logic [7:0] dwell_d [6];

  logic shoot;
  logic desat_flt;
  logic desat_clear;
  logic fault_cond;
  logic idle_entry;

  // Upper and lower switch pairs of the same half must never be on together.
  assign shoot = (s_in[5] & s_in[3]) | (s_in[4] & s_in[2]);

`ifdef GATE_GUARD_DESAT_EN
  localparam logic [3:0] FILT_MAX = 4'(FLT_FILT);

  logic [3:0] filt_q [6];
  logic [3:0] filt_d [6];
  logic [5:0] desat_hit;

  // The hit uses the next filter value so the fault is taken on the edge the count reaches FLT_FILT.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      filt_d[i]    = filt_q[i];
      desat_hit[i] = 1'b0;
      if (desat_n[i]) begin
        filt_d[i] = 4'd0;
      end else if (ce && (filt_q[i] < FILT_MAX)) begin
        filt_d[i] = filt_q[i] + 4'd1;
      end
      desat_hit[i] = (filt_d[i] >= FILT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) filt_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 6; i++) filt_q[i] <= filt_d[i];
    end
  end

  assign desat_flt   = |desat_hit;
  assign desat_clear = &desat_n;
`else
  logic unused_desat;
  assign unused_desat = ^desat_n;
  assign desat_flt    = 1'b0;
  assign desat_clear  = 1'b1;
`endif

  assign fault_cond = shoot | desat_flt;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (en && !fault_cond) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fault_cond) begin
          state_d = ST_FAULT;
          code_d  = {desat_flt, shoot};
        end else if (!en) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (flt_clr && (s_in == 6'd0) && desat_clear) begin
          state_d = ST_IDLE;
          code_d  = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = 2'd0;
      end
    endcase
  end

  assign idle_entry = (state_d == ST_IDLE) && (state_q != ST_IDLE);

  // Outputs are only driven while staying in RUN; any other edge forces them off.
  always_comb begin
    s_out_d = s_out_q;
    if ((state_q != ST_RUN) || (state_d != ST_RUN)) begin
      s_out_d = 6'd0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (ce && (s_in[i] != s_out_q[i]) && (dwell_q[i] >= t_min)) s_out_d[i] = s_in[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      dwell_d[i] = dwell_q[i];
      if (idle_entry || (s_out_d[i] != s_out_q[i])) begin
        dwell_d[i] = 8'd0;
      end else if (ce && (dwell_q[i] != 8'hFF)) begin
        dwell_d[i] = dwell_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      code_q  <= 2'd0;
      s_out_q <= 6'd0;
      for (int i = 0; i < 6; i++) dwell_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      s_out_q <= s_out_d;
      for (int i = 0; i < 6; i++) dwell_q[i] <= dwell_d[i];
    end
  end

  assign s_out      = s_out_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gate_guard_3l.sv
// Self-checking bench for gate_guard_3l: directed protection scenarios plus a random follow phase.
// Observations are packed as {state, fault, fault_code, s_out} and checked against a scoreboard queue.
module tb_gate_guard_3l;
  localparam int W = 11;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FLT  = 2'd2;
`ifdef GATE_GUARD_DESAT_EN
  localparam bit DESAT = 1'b1;
`else
  localparam bit DESAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ce;
  logic       en;
  logic [5:0] s_in;
  logic [7:0] t_min;
  logic [5:0] desat_n;
  logic       flt_clr;
  logic [5:0] s_out;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  gate_guard_3l #(.FLT_FILT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .en         (en),
    .s_in       (s_in),
    .t_min      (t_min),
    .desat_n    (desat_n),
    .flt_clr    (flt_clr),
    .s_out      (s_out),
    .fault      (fault),
    .fault_code (fault_code),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [1:0] st, input logic f,
                                        input logic [1:0] c, input logic [5:0] o);
    return {st, f, c, o};
  endfunction

  function automatic logic [W-1:0] observe();
    return {dbg_state, fault, fault_code, s_out};
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d f=%0b code=%0d s_out=%b, want st=%0d f=%0b code=%0d s_out=%b",
               tag, obs[10:9], obs[8], obs[7:6], obs[5:0], exp[10:9], exp[8], exp[7:6], exp[5:0]);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic f, input logic [1:0] c, input logic [5:0] o);
    exp_q.push_back(pack(st, f, c, o));
  endtask

  // Pop one expectation and compare against the DUT right now.
  task automatic compare_now(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(tag, observe(), exp_q.pop_front());
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    @(negedge clk);
    compare_now(tag);
  endtask

  task automatic expect_step(input string tag, input logic [1:0] st, input logic f,
                             input logic [1:0] c, input logic [5:0] o);
    push(st, f, c, o);
    step(tag);
  endtask

  initial begin
    logic [5:0] r;
    rst = 1'b0; ce = 1'b1; en = 1'b0; s_in = 6'd0; t_min = 8'd0;
    desat_n = 6'h3F; flt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push(IDLE, 1'b0, 2'd0, 6'd0);
    compare_now("reset_state");
    rst = 1'b1;

    // basic run with t_min=0
    en = 1'b1;
    expect_step("idle_to_run", RUN, 1'b0, 2'd0, 6'd0);
    s_in = 6'b011000;
    expect_step("follow_011000", RUN, 1'b0, 2'd0, 6'b011000);

    // random safe patterns, one-clock follow
    for (int k = 0; k < 8; k++) begin
      r = 6'($urandom_range(0, 63));
      if ((r[5] & r[3]) | (r[4] & r[2])) r[3:2] = 2'b00;
      s_in = r;
      expect_step("rand_follow", RUN, 1'b0, 2'd0, r);
    end

    // dwell: bit5 toggles 3 ce cycles after its last change, with a ce pause
    s_in = 6'd0;
    expect_step("dwell_prep0", RUN, 1'b0, 2'd0, 6'd0);
    s_in = 6'b100000;
    expect_step("dwell_prep1", RUN, 1'b0, 2'd0, 6'b100000);
    t_min = 8'd10;
    for (int k = 0; k < 3; k++) expect_step("dwell_settle", RUN, 1'b0, 2'd0, 6'b100000);
    s_in = 6'd0;
    for (int k = 0; k < 9; k++) push(RUN, 1'b0, 2'd0, 6'b100000);
    push(RUN, 1'b0, 2'd0, 6'd0);
    for (int k = 0; k < 10; k++) begin
      ce = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      step(k < 9 ? "dwell_hold" : "dwell_release");
    end
    ce = 1'b1;

    // shoot-through fault and ignored clear
    t_min = 8'd0;
    s_in = 6'b101000;
    expect_step("shoot_fault", FLT, 1'b1, 2'd1, 6'd0);
    flt_clr = 1'b1;
    expect_step("clr_ignored", FLT, 1'b1, 2'd1, 6'd0);
    s_in = 6'd0;
    expect_step("clr_accept", IDLE, 1'b0, 2'd0, 6'd0);
    flt_clr = 1'b0;
    expect_step("rerun", RUN, 1'b0, 2'd0, 6'd0);

    // desat filter: 3 low cycles do not trip, 4 do
    desat_n[2] = 1'b0;
    for (int k = 0; k < 3; k++) expect_step("desat_short", RUN, 1'b0, 2'd0, 6'd0);
    desat_n[2] = 1'b1;
    expect_step("desat_release", RUN, 1'b0, 2'd0, 6'd0);
    desat_n[2] = 1'b0;
    for (int k = 0; k < 3; k++) expect_step("desat_count", RUN, 1'b0, 2'd0, 6'd0);
    expect_step("desat_fault", DESAT ? FLT : RUN, DESAT, DESAT ? 2'd2 : 2'd0, 6'd0);
    desat_n = 6'h3F;
    flt_clr = 1'b1;
    expect_step("desat_clr", DESAT ? IDLE : RUN, 1'b0, 2'd0, 6'd0);
    flt_clr = 1'b0;
    expect_step("desat_rerun", RUN, 1'b0, 2'd0, 6'd0);

    // both causes in the same cycle
    desat_n[2] = 1'b0;
    for (int k = 0; k < 3; k++) expect_step("both_pre", RUN, 1'b0, 2'd0, 6'd0);
    s_in = 6'b101000;
    expect_step("both_fault", FLT, 1'b1, DESAT ? 2'd3 : 2'd1, 6'd0);
    en = 1'b0;
    s_in = 6'd0;
    flt_clr = 1'b1;
    expect_step("both_clr_desat_low", DESAT ? FLT : IDLE, DESAT, DESAT ? 2'd3 : 2'd0, 6'd0);
    desat_n = 6'h3F;
    expect_step("both_clr", IDLE, 1'b0, 2'd0, 6'd0);
    flt_clr = 1'b0;

    // asynchronous reset while driving
    en = 1'b1;
    s_in = 6'b110000;
    expect_step("pre_rst_run", RUN, 1'b0, 2'd0, 6'd0);
    expect_step("pre_rst_out", RUN, 1'b0, 2'd0, 6'b110000);
    #2 rst = 1'b0;
    #1;
    push(IDLE, 1'b0, 2'd0, 6'd0);
    compare_now("rst_async");
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_step("no_autostart", IDLE, 1'b0, 2'd0, 6'd0);
    en = 1'b1;
    expect_step("post_rst_run", RUN, 1'b0, 2'd0, 6'd0);
    expect_step("post_rst_out", RUN, 1'b0, 2'd0, 6'b110000);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/gate_guard_3l.md
GATE_GUARD_3L -- requirements
Module: gate_guard_3l

Interface
REQ-001 SHALL have parameter FLT_FILT, default 4, consecutive qualifying cycles required to accept a desaturation fault (range 1..15).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ce  input  1  clock enable for counters and filters.
REQ-005 SHALL have port en  input  1  run request; 0 forces all gates off.
REQ-006 SHALL have port s_in  input  6  gate commands from the 3-level decoder, bit5=S_1 ... bit0=S_6.
REQ-007 SHALL have port t_min  input  8  minimum on/off dwell, in ce cycles.
REQ-008 SHALL have port desat_n  input  6  driver desaturation flags, active-low, one per switch.
REQ-009 SHALL have port flt_clr  input  1  single-cycle fault clear request.
REQ-010 SHALL have port s_out  output  6  protected gate drive, same bit order as s_in.
REQ-011 SHALL have port fault  output  1  high while in FAULT.
REQ-012 SHALL have port fault_code  output  2  latched cause: 0 none, 1 shoot-through, 2 desat, 3 both.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and FAULT, all registered.
REQ-014 IDLE: s_out=0; SHALL go to RUN when en=1 and no fault condition is present.
REQ-015 RUN: per-switch dwell filtering per REQ-017; SHALL go to IDLE when en=0; SHALL go to FAULT on any fault condition, with fault taking priority over en=0.
REQ-016 FAULT: s_out=0 and fault=1; SHALL go to IDLE only on flt_clr=1 with s_in==0 and desat_n==6'b111111, and flt_clr SHALL be ignored otherwise.
REQ-017 Each switch SHALL own an 8-bit dwell counter that counts on ce=1, saturates at 255, and clears to 0 when its s_out bit changes.
REQ-018 In RUN, s_out[i] SHALL take s_in[i] on the edge where s_in[i]!=s_out[i] and counter[i]>=t_min; otherwise it holds.
REQ-019 The latency from an s_in change to s_out SHALL be 1 clk when the dwell is already satisfied.
REQ-020 With t_min=0, s_out SHALL follow s_in with 1-clk latency.
REQ-021 Shoot-through SHALL be (s_in[5]&s_in[3]) or (s_in[4]&s_in[2]), evaluated every clk regardless of ce.
REQ-022 Each desat_n bit SHALL have a 4-bit filter that increments on ce=1 while the bit is low, clears when the bit is high, and flags a fault on reaching FLT_FILT.
REQ-023 Entry into FAULT or IDLE SHALL force s_out=0 on the next edge, bypassing dwell.
REQ-024 All dwell counters SHALL clear on any entry into IDLE.
REQ-025 fault_code SHALL latch on FAULT entry: 3 if both causes are present in the same cycle; later causes SHALL NOT modify it.
REQ-026 fault_code SHALL clear to 0 on the FAULT-to-IDLE transition.
REQ-027 With ce=0: dwell counters and desat filters hold, s_out holds in RUN, and FSM transitions still occur.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, s_out=0, fault=0, fault_code=0, and all counters and filters to 0.
REQ-029 Reset asserted mid-pulse or in FAULT SHALL take effect immediately, with no dependence on clk.
REQ-030 After rst deassertion, the block SHALL require en=1 to reach RUN; it SHALL NOT auto-start.

Configuration
REQ-031 Macro GATE_GUARD_DESAT_EN defined: desat_n filtering and the desat fault SHALL be present per REQ-022.
REQ-032 Macro GATE_GUARD_DESAT_EN undefined: desat_n SHALL remain on the port list but be ignored, filters SHALL be removed, and fault_code values 2 and 3 SHALL never occur.

Verification
REQ-033 Bench SHALL cover: reset, en=1, t_min=0, ce=1, s_in=6'b011000 -> s_out=6'b011000 one clk later; fault=0.
REQ-034 Bench SHALL cover: t_min=10, s_in bit5 toggled 3 ce cycles after its last s_out change -> s_out[5] changes exactly when counter reaches 10.
REQ-035 Bench SHALL cover: in RUN, s_in=6'b101000 -> next edge FAULT, s_out=0, fault_code=1; flt_clr with s_in!=0 -> remains FAULT.
REQ-036 Bench SHALL cover (GATE_GUARD_DESAT_EN, FLT_FILT=4): desat_n[2] low 3 cycles then high -> no fault; low 4 cycles -> FAULT, fault_code=2.
REQ-037 Bench SHALL cover: shoot-through and a filtered desat fault in the same cycle -> fault_code=3; flt_clr with s_in=0 and desat_n all high -> IDLE, fault_code=0.
REQ-038 Bench SHALL cover: rst pulsed low between clk edges while s_out=6'b110000 -> s_out=0 immediately, with state IDLE.
